// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt sequencer: sequencer states and request-line constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pic_pkg;

    localparam int NUM_IR = 8;
    localparam int ID_W   = 3;

    // Id returned when an acknowledge finds no request left to serve.
    localparam logic [ID_W-1:0] SPURIOUS_ID = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_ACK1 = 2'd2
    } state_t;

endpackage

// File: rtl/priority_resolver.sv
// Lowest-index encoder: reports whether any bit is set and the index of the lowest set bit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its input.
module priority_resolver
    import pic_pkg::*;
(
    input  logic [NUM_IR-1:0] req,
    output logic              vld,
    output logic [ID_W-1:0]   id
);

    // Scan from the top so the lowest set index is the last one written.
    always_comb begin
        vld = |req;
        id  = '0;
        for (int i = NUM_IR - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// Priority interrupt sequencer: edge-latched requests, nested in-service tracking, two-pulse acknowledge.
// Latency: ir_req edge -> irr next cycle; pending -> int_out one cycle later; vector strobe the cycle after the second inta.
// Backpressure: none; the CPU paces the sequence with inta and eoi pulses, and requests wait in irr.
module interrupt_sequencer
    import pic_pkg::*;
#(
    parameter logic [4:0] VECTOR_BASE = 5'b00001,
    parameter bit         AUTO_EOI    = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_IR-1:0] ir_req,
    input  logic [NUM_IR-1:0] imr,
    input  logic              inta,
    input  logic              eoi,
    output logic              int_out,
    output logic [7:0]        vector_out,
    output logic              vector_valid,
    output logic [NUM_IR-1:0] irr,
    output logic [NUM_IR-1:0] isr
);

    state_t            state, state_n;
    logic [NUM_IR-1:0] prev_req;
    logic [NUM_IR-1:0] irr_n, isr_n;
    logic [ID_W-1:0]   cap_id, cap_id_n;
    logic              cap_spur, cap_spur_n;
    logic              int_n;
    logic [7:0]        vec_n;
    logic              vec_vld_n;

    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    logic              srv_vld;
    logic [ID_W-1:0]   srv_id;
    logic              pending;

    // Highest-priority unmasked request.
    priority_resolver u_win (
        .req (irr & ~imr),
        .vld (win_vld),
        .id  (win_id)
    );

    // Highest-priority in-service level; also the bit a non-specific EOI retires.
    priority_resolver u_srv (
        .req (isr),
        .vld (srv_vld),
        .id  (srv_id)
    );

    // Only a strictly higher priority than everything in service may interrupt (nesting).
    assign pending = win_vld && !(srv_vld && (srv_id <= win_id));

    // Next-state, request/service register updates and acknowledge outputs.
    always_comb begin
        state_n    = state;
        // New rising edges set, a low level clears; since a set needs ir_req high the clear always wins.
        irr_n      = (irr | (ir_req & ~prev_req)) & ir_req;
        isr_n      = isr;
        cap_id_n   = cap_id;
        cap_spur_n = cap_spur;
        vec_n      = '0;
        vec_vld_n  = 1'b0;

        if (eoi && srv_vld) begin
            isr_n[srv_id] = 1'b0;
        end

        case (state)
            ST_IDLE: begin
                if (inta) begin
                    cap_id_n   = SPURIOUS_ID;
                    cap_spur_n = 1'b1;
                    state_n    = ST_ACK1;
                end else if (pending) begin
                    state_n = ST_REQ;
                end
            end
            ST_REQ: begin
                if (inta) begin
                    if (pending) begin
                        isr_n[win_id] = 1'b1;
                        irr_n[win_id] = 1'b0;
                        cap_id_n      = win_id;
                        cap_spur_n    = 1'b0;
                    end else begin
                        cap_id_n   = SPURIOUS_ID;
                        cap_spur_n = 1'b1;
                    end
                    state_n = ST_ACK1;
                end else if (!pending) begin
                    state_n = ST_IDLE;
                end
            end
            ST_ACK1: begin
                if (inta) begin
                    vec_n     = {VECTOR_BASE, cap_id};
                    vec_vld_n = 1'b1;
                    if (AUTO_EOI && !cap_spur) begin
                        isr_n[cap_id] = 1'b0;
                    end
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase

        int_n = (state_n == ST_REQ);
    end

    // State and output registers; reset abandons any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            prev_req     <= '0;
            irr          <= '0;
            isr          <= '0;
            cap_id       <= '0;
            cap_spur     <= 1'b0;
            int_out      <= 1'b0;
            vector_out   <= '0;
            vector_valid <= 1'b0;
        end else begin
            state        <= state_n;
            prev_req     <= ir_req;
            irr          <= irr_n;
            isr          <= isr_n;
            cap_id       <= cap_id_n;
            cap_spur     <= cap_spur_n;
            int_out      <= int_n;
            vector_out   <= vec_n;
            vector_valid <= vec_vld_n;
        end
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;

    logic       clk = 1'b0;
    logic       rst, rst_b;
    logic [7:0] ir_req, imr, ir_req_b;
    logic       inta, eoi, inta_b;

    logic       int_out, vector_valid, int_out_b, vector_valid_b;
    logic [7:0] vector_out, irr, isr, vector_out_b, irr_b, isr_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    interrupt_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .ir_req       (ir_req),
        .imr          (imr),
        .inta         (inta),
        .eoi          (eoi),
        .int_out      (int_out),
        .vector_out   (vector_out),
        .vector_valid (vector_valid),
        .irr          (irr),
        .isr          (isr)
    );

    interrupt_sequencer #(.VECTOR_BASE(5'b00001), .AUTO_EOI(1'b1)) dut_auto (
        .clk          (clk),
        .rst          (rst_b),
        .ir_req       (ir_req_b),
        .imr          (8'h00),
        .inta         (inta_b),
        .eoi          (1'b0),
        .int_out      (int_out_b),
        .vector_out   (vector_out_b),
        .vector_valid (vector_valid_b),
        .irr          (irr_b),
        .isr          (isr_b)
    );

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rst_b = 1'b1;
        ir_req = '0; imr = '0; inta = 1'b0; eoi = 1'b0;
        ir_req_b = '0; inta_b = 1'b0;
        step(); step();
        chk("rst_int_out", {7'd0, int_out}, 8'h00);
        chk("rst_irr", irr, 8'h00);
        chk("rst_isr", isr, 8'h00);
        chk("rst_vec", vector_out, 8'h00);
        chk("rst_vv", {7'd0, vector_valid}, 8'h00);
        rst = 1'b0; rst_b = 1'b0;
        step();

        // Basic sequence on IR2
        ir_req = 8'h04;
        step();
        chk("b_irr_set", irr, 8'h04);
        chk("b_int_lat", {7'd0, int_out}, 8'h00);
        step();
        chk("b_int_out", {7'd0, int_out}, 8'h01);
        inta = 1'b1;
        step();
        inta = 1'b0;
        chk("b_isr", isr, 8'h04);
        chk("b_irr_clr", irr, 8'h00);
        chk("b_int_drop", {7'd0, int_out}, 8'h00);
        chk("b_vv_early", {7'd0, vector_valid}, 8'h00);
        inta = 1'b1;
        step();
        inta = 1'b0;
        chk("b_vv", {7'd0, vector_valid}, 8'h01);
        chk("b_vec", vector_out, 8'h0A);
        step();
        chk("b_vv_one", {7'd0, vector_valid}, 8'h00);
        chk("b_int_idle", {7'd0, int_out}, 8'h00);

        // Nesting: IR1 preempts IR2 in service
        ir_req = 8'h06;
        step();
        chk("n_irr", irr, 8'h02);
        step();
        chk("n_int_out", {7'd0, int_out}, 8'h01);
        inta = 1'b1;
        step();
        step();
        inta = 1'b0;
        chk("n_vec", vector_out, 8'h09);
        chk("n_isr", isr, 8'h06);
        // Lower priority IR5 must not interrupt
        ir_req = 8'h26;
        step();
        chk("n_irr5", irr, 8'h20);
        step();
        chk("n_ir5_int", {7'd0, int_out}, 8'h00);
        step();
        chk("n_ir5_int2", {7'd0, int_out}, 8'h00);

        // Non-specific EOI
        ir_req = 8'h06;
        step();
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        chk("e_isr1", isr, 8'h04);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        chk("e_isr2", isr, 8'h00);
        eoi = 1'b1;
        step();
        eoi = 1'b0;
        chk("e_isr3", isr, 8'h00);

        // Withdrawn request -> spurious vector
        ir_req = 8'h00;
        step();
        ir_req = 8'h08;
        step();
        step();
        chk("s_int_out", {7'd0, int_out}, 8'h01);
        ir_req = 8'h00;
        step();
        chk("s_irr_clr", irr, 8'h00);
        inta = 1'b1;
        step();
        chk("s_isr", isr, 8'h00);
        step();
        inta = 1'b0;
        chk("s_vec", vector_out, 8'h0F);
        chk("s_vv", {7'd0, vector_valid}, 8'h01);

        // Masking
        imr = 8'hFF;
        ir_req = 8'hFF;
        step();
        chk("m_irr", irr, 8'hFF);
        step();
        step();
        chk("m_int_masked", {7'd0, int_out}, 8'h00);
        imr = 8'hF7;
        step();
        chk("m_int_out", {7'd0, int_out}, 8'h01);
        inta = 1'b1;
        step();
        chk("m_isr", isr, 8'h08);
        chk("m_irr", irr, 8'hF7);
        step();
        inta = 1'b0;
        chk("m_vec", vector_out, 8'h0B);

        // AUTO_EOI instance: IR6
        ir_req_b = 8'h40;
        step();
        step();
        chk("a_int_out", {7'd0, int_out_b}, 8'h01);
        inta_b = 1'b1;
        step();
        chk("a_isr_set", isr_b, 8'h40);
        step();
        inta_b = 1'b0;
        chk("a_vec", vector_out_b, 8'h0E);
        chk("a_isr_auto", isr_b, 8'h00);

        // Reset in ACK1 abandons the sequence
        ir_req_b = 8'h00;
        step();
        ir_req_b = 8'h40;
        step();
        step();
        inta_b = 1'b1;
        step();
        chk("r_isr_pre", isr_b, 8'h40);
        rst_b = 1'b1;
        #1;
        chk("r_isr", isr_b, 8'h00);
        chk("r_irr", irr_b, 8'h00);
        chk("r_int", {7'd0, int_out_b}, 8'h00);
        chk("r_vec", vector_out_b, 8'h00);
        step();
        chk("r_vv", {7'd0, vector_valid_b}, 8'h00);
        rst_b = 1'b0;
        inta_b = 1'b0;
        step();
        chk("r_vv_after", {7'd0, vector_valid_b}, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
